// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with per-requester burst weights, request mask
// and per-requester lock. One registered grant per cycle, no idle bubble
// between consecutive owners.
//
// Ports:
//   clk            clock, all logic on posedge
//   rst            synchronous reset, active-high
//   init_in        synchronous re-init of pointer/state/credit/outputs
//   en_in          arbitration enable
//   req_in         request vector
//   mask_in        1 = requester excluded from arbitration
//   lock_in        1 = current owner keeps the grant regardless of credit
//   weight_in      burst length per requester, slice i = requester i
//   granted_out    a grant is active
//   grant_out      one-hot grant
//   grant_idx_out  owner index + 1, 0 = no grant
module arbiter_wrr #(
  parameter int unsigned NUM_REQUEST     = 4,
  parameter int unsigned REQ_INDEX_WIDTH = $clog2(NUM_REQUEST) + 1,
  parameter int unsigned WEIGHT_WIDTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  init_in,
  input  logic                                  en_in,
  input  logic [NUM_REQUEST-1:0]                req_in,
  input  logic [NUM_REQUEST-1:0]                mask_in,
  input  logic [NUM_REQUEST-1:0]                lock_in,
  input  logic [NUM_REQUEST*WEIGHT_WIDTH-1:0]   weight_in,
  output logic                                  granted_out,
  output logic [NUM_REQUEST-1:0]                grant_out,
  output logic [REQ_INDEX_WIDTH-1:0]            grant_idx_out
);

  localparam int unsigned PTR_W = (NUM_REQUEST > 1) ? $clog2(NUM_REQUEST) : 1;
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_REQUEST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             last_q, last_d;
  logic [WEIGHT_WIDTH-1:0]      credit_q, credit_d;
  logic [NUM_REQUEST-1:0]       grant_q, grant_d;
  logic [REQ_INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic                         granted_q, granted_d;

  logic [NUM_REQUEST-1:0]       eligible;
  logic [WEIGHT_WIDTH-1:0]      weight_a [NUM_REQUEST];
  logic [WEIGHT_WIDTH-1:0]      w_sel;
  logic [PTR_W-1:0]             cand;
  logic [PTR_W-1:0]             pick;
  logic                         found;
  logic                         stay;

  // Unpack the flat weight bus into per-requester slices
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
      weight_a[i] = weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // Cyclic search starting after the last owner; the last owner is tried last,
  // which also re-grants a sole continuous requester on credit expiry
  always_comb begin
    eligible = req_in & ~mask_in;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQUEST; k++) begin
      cand = PTR_W'((32'(last_q) + k) % NUM_REQUEST);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    w_sel = weight_a[pick];
  end

  // In GRANT the pointer equals the current owner
  assign stay = (state_q == ST_GRANT) && eligible[last_q] &&
                ((credit_q != '0) || lock_in[last_q]);

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    credit_d  = credit_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    granted_d = granted_q;

    if (init_in) begin
      state_d   = ST_IDLE;
      last_d    = LAST_RST;
      credit_d  = '0;
      grant_d   = '0;
      idx_d     = '0;
      granted_d = 1'b0;
    end else if (!en_in) begin
      state_d   = ST_IDLE;
      credit_d  = '0;
      grant_d   = '0;
      idx_d     = '0;
      granted_d = 1'b0;
    end else if (stay) begin
      if (!lock_in[last_q]) begin
        credit_d = credit_q - WEIGHT_WIDTH'(1);
      end
    end else if (found) begin
      state_d   = ST_GRANT;
      last_d    = pick;
      // weight 0 behaves as a single-cycle burst
      credit_d  = (w_sel == '0) ? '0 : (w_sel - WEIGHT_WIDTH'(1));
      grant_d   = NUM_REQUEST'(1) << pick;
      idx_d     = REQ_INDEX_WIDTH'(pick) + REQ_INDEX_WIDTH'(1);
      granted_d = 1'b1;
    end else begin
      state_d   = ST_IDLE;
      credit_d  = '0;
      grant_d   = '0;
      idx_d     = '0;
      granted_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_RST;
      credit_q  <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      credit_q  <= credit_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      granted_q <= granted_d;
    end
  end

  assign granted_out   = granted_q;
  assign grant_out     = grant_q;
  assign grant_idx_out = idx_q;

endmodule
